// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin arbiter merging NUM_REQ
// AXI-Stream requesters onto one stream toward the network TX FIFO.
// A grant is held from the first beat until the accepted tlast beat, so
// frames never interleave; one IDLE bubble separates consecutive packets.
// Optional feature: define ARB_PKT_LEN_LIMIT_EN to enable the length
// watchdog (truncate at MAX_PKT_LEN beats, drain the remainder, flag it).
module axis_pkt_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_PKT_LEN = 1518
) (
   input  logic                                            axis_aclk,
   input  logic                                            axis_aresetn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]                   s_axis_tdata,
   input  logic [NUM_REQ-1:0]                              s_axis_tvalid,
   input  logic [NUM_REQ-1:0]                              s_axis_tlast,
   output logic [NUM_REQ-1:0]                              s_axis_tready,
   output logic [DATA_WIDTH-1:0]                           m_axis_tdata,
   output logic                                            m_axis_tvalid,
   output logic                                            m_axis_tlast,
   input  logic                                            m_axis_tready,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                                            busy,
   output logic                                            pkt_trunc
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ARB_PKT_LEN_LIMIT_EN
   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_e;
`else
   typedef enum logic [0:0] {S_IDLE, S_XFER} state_e;
`endif

   state_e        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;

`ifdef ARB_PKT_LEN_LIMIT_EN
   logic [CW-1:0] cnt_q, cnt_d;
   logic          trunc_q, trunc_d;
   logic          at_limit;
`endif

   // per-requester data slices, indexable by grant
   logic [DATA_WIDTH-1:0] s_data [NUM_REQ];
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign s_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // round-robin pointer after serving the current grant, wrapping at NUM_REQ
   logic [GW:0]   g_inc;
   logic [GW-1:0] ptr_next;
   assign g_inc    = {1'b0, grant_q} + (GW+1)'(1);
   assign ptr_next = (g_inc == (GW+1)'(NUM_REQ)) ? '0 : g_inc[GW-1:0];

`ifdef ARB_PKT_LEN_LIMIT_EN
   // current beat is beat number MAX_PKT_LEN of the packet
   assign at_limit = (cnt_q == CW'(MAX_PKT_LEN - 1));
`endif

   // winner search: first valid requester starting at rr_ptr, wrapping
   logic [GW-1:0] win;
   logic          win_vld;
   logic [GW:0]   cand;
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
         if (!win_vld && s_axis_tvalid[cand[GW-1:0]]) begin
            win_vld = 1'b1;
            win     = cand[GW-1:0];
         end
      end
   end

   // next-state logic and stream muxing
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
`ifdef ARB_PKT_LEN_LIMIT_EN
      cnt_d         = cnt_q;
      trunc_d       = trunc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               grant_d = win;
               state_d = S_XFER;
`ifdef ARB_PKT_LEN_LIMIT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_XFER: begin
            m_axis_tdata           = s_data[grant_q];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
`ifdef ARB_PKT_LEN_LIMIT_EN
            m_axis_tlast           = s_axis_tlast[grant_q] | at_limit;
`else
            m_axis_tlast           = s_axis_tlast[grant_q];
`endif
            s_axis_tready[grant_q] = m_axis_tready;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               rr_ptr_d = ptr_next;
               state_d  = S_IDLE;
            end
`ifdef ARB_PKT_LEN_LIMIT_EN
            if (m_axis_tvalid && m_axis_tready) begin
               cnt_d = cnt_q + CW'(1);
               // forced tlast on a runaway packet: discard the tail instead
               if (at_limit && !s_axis_tlast[grant_q]) begin
                  rr_ptr_d = rr_ptr_q;
                  trunc_d  = 1'b1;
                  state_d  = S_DRAIN;
               end
            end
`endif
         end
`ifdef ARB_PKT_LEN_LIMIT_EN
         S_DRAIN: begin
            s_axis_tready[grant_q] = 1'b1;
            if (s_axis_tvalid[grant_q] && s_axis_tlast[grant_q]) begin
               rr_ptr_d = ptr_next;
               state_d  = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // state registers, cleared asynchronously
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
`ifdef ARB_PKT_LEN_LIMIT_EN
         cnt_q    <= '0;
         trunc_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef ARB_PKT_LEN_LIMIT_EN
         cnt_q    <= cnt_d;
         trunc_q  <= trunc_d;
`endif
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q != S_IDLE);
`ifdef ARB_PKT_LEN_LIMIT_EN
   assign pkt_trunc = trunc_q;
`else
   assign pkt_trunc = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: per-requester drivers feed beat
// queues, main pushes hand-ordered expected beats, a negedge monitor pops
// and compares every accepted output beat.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;
   localparam int NR = 2, DW = 8, MAXL = 8;
`ifdef ARB_PKT_LEN_LIMIT_EN
   localparam int TRUNC_EXP = 1;
`else
   localparam int TRUNC_EXP = 0;
`endif

   typedef struct packed { logic gid; logic last; logic [7:0] data; } beat_t;

   logic          clk, rst_n;
   logic          tv0, tv1, tl0, tl1;
   logic [7:0]    td0, td1;
   logic [15:0]   s_tdata;
   logic [1:0]    s_tvalid, s_tlast, s_tready;
   logic [7:0]    m_tdata;
   logic          m_tvalid, m_tlast, m_tready;
   logic [0:0]    grant_id;
   logic          busy, pkt_trunc;
   logic          bp_mode;

   assign s_tdata  = {td1, td0};
   assign s_tvalid = {tv1, tv0};
   assign s_tlast  = {tl1, tl0};

   axis_pkt_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
      .axis_aclk(clk), .axis_aresetn(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .grant_id(grant_id), .busy(busy), .pkt_trunc(pkt_trunc)
   );

   logic [8:0] rq0[$], rq1[$];
   beat_t      exp_q[$];
   int         bc[$];
   int         n_beats = 0, cyc = 0, n_chk = 0, n_pass = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic send(input int req, input int base, input int len);
      logic [8:0] b;
      for (int k = 0; k < len; k++) begin
         b = {(k == len - 1), 8'(base + k)};
         if (req == 0) rq0.push_back(b); else rq1.push_back(b);
      end
   endtask

   task automatic expect_pkt(input int gid, input int base, input int n, input int last_at);
      beat_t e;
      for (int k = 0; k < n; k++) begin
         e.gid  = 1'(gid);
         e.last = (k + 1 == last_at);
         e.data = 8'(base + k);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string nm, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(nm, int'(c < budget), 1);
      repeat (3) @(negedge clk);
   endtask

   // requester 0 driver: present queue head, pop after an accepted beat
   initial begin : drv0
      logic take;
      tv0 = 1'b0; tl0 = 1'b0; td0 = '0;
      forever begin
         @(negedge clk);
         take = tv0 && s_tready[0];
         @(posedge clk); #1;
         if (take && rq0.size() > 0) void'(rq0.pop_front());
         if (rq0.size() > 0) begin
            tv0 = 1'b1; td0 = rq0[0][7:0]; tl0 = rq0[0][8];
         end else begin
            tv0 = 1'b0; tl0 = 1'b0;
         end
      end
   end

   // requester 1 driver
   initial begin : drv1
      logic take;
      tv1 = 1'b0; tl1 = 1'b0; td1 = '0;
      forever begin
         @(negedge clk);
         take = tv1 && s_tready[1];
         @(posedge clk); #1;
         if (take && rq1.size() > 0) void'(rq1.pop_front());
         if (rq1.size() > 0) begin
            tv1 = 1'b1; td1 = rq1[0][7:0]; tl1 = rq1[0][8];
         end else begin
            tv1 = 1'b0; tl1 = 1'b0;
         end
      end
   end

   // downstream ready: constant 1, or toggling when backpressure is enabled
   initial begin : rdy
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) m_tready = ~m_tready;
         else         m_tready = 1'b1;
      end
   end

   // monitor: compare each accepted output beat against the scoreboard
   initial begin : mon
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", int'(m_tdata), -1);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", int'(m_tdata), int'(e.data));
               chk("beat_last", int'(m_tlast), int'(e.last));
               chk("beat_gid", int'(grant_id), int'(e.gid));
            end
            bc.push_back(cyc);
            n_beats++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] vt, vb;
      int c, tgt, nb;
      rst_n = 1'b0; bp_mode = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst_s_tready", int'(s_tready), 0);
      chk("rst_m_tvalid", int'(m_tvalid), 0);
      chk("rst_m_tlast", int'(m_tlast), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant", int'(grant_id), 0);
      chk("rst_trunc", int'(pkt_trunc), 0);
      @(negedge clk); rst_n = 1'b1;

      // contention: both offer two 3-beat packets, strict alternation
      @(posedge clk); #2;
      bc.delete();
      send(0, 'h01, 3); send(0, 'h04, 3); send(1, 'h11, 3); send(1, 'h14, 3);
      expect_pkt(0, 'h01, 3, 3); expect_pkt(1, 'h11, 3, 3);
      expect_pkt(0, 'h04, 3, 3); expect_pkt(1, 'h14, 3, 3);
      wait_done("cont_done", 100);
      chk("cont_nbeats", bc.size(), 12);
      if (bc.size() == 12) begin
         chk("cont_burst", bc[2] - bc[0], 2);
         chk("cont_gap1", bc[3] - bc[2], 2);
         chk("cont_gap2", bc[6] - bc[5], 2);
         chk("cont_gap3", bc[9] - bc[8], 2);
      end

      // single requester: 4-beat packet, one cycle of arbitration latency
      @(posedge clk); #2;
      send(0, 'hA1, 4); expect_pkt(0, 'hA1, 4, 4);
      vt = '0; vb = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vt[i] = m_tvalid;
         vb[i] = busy;
      end
      chk("single_tvalid_pat", int'(vt), 'h3C);
      chk("single_busy_pat", int'(vb), 'h3C);
      chk("single_grant", int'(grant_id), 0);
      wait_done("single_done", 20);

      // backpressure on a 5-beat req1 packet
      @(posedge clk); #2;
      send(1, 'hB1, 5); expect_pkt(1, 'hB1, 5, 5);
      bp_mode = 1'b1;
      c = 0;
      while (exp_q.size() != 0 && c < 60) begin
         @(negedge clk);
         c++;
         if (busy) begin
            chk("bp_tready1", int'(s_tready[1]), int'(m_tready));
            chk("bp_tready0", int'(s_tready[0]), 0);
         end
      end
      chk("bp_done", int'(c < 60), 1);
      @(posedge clk); #2;
      bp_mode = 1'b0;
      wait_done("bp_drain", 20);

      // long packet from req0 with req1 waiting (truncated when watchdog on)
      @(posedge clk); #2;
      send(0, 'h21, 12); send(1, 'h61, 2);
`ifdef ARB_PKT_LEN_LIMIT_EN
      expect_pkt(0, 'h21, 8, 8);
`else
      expect_pkt(0, 'h21, 12, 12);
`endif
      expect_pkt(1, 'h61, 2, 2);
      wait_done("long_done", 100);
      chk("long_pkt_trunc", int'(pkt_trunc), TRUNC_EXP);

      // single-beat packet occupies XFER for exactly one cycle; rr_ptr -> 1
      @(posedge clk); #2;
      send(0, 'hC1, 1); expect_pkt(0, 'hC1, 1, 1);
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      chk("one_beat_busy_cycles", nb, 1);
      wait_done("one_beat_done", 20);

      // reset after beat 2 of a 6-beat req1 packet
      @(posedge clk); #2;
      send(1, 'h41, 6); expect_pkt(1, 'h41, 2, 0);
      tgt = n_beats + 2;
      c = 0;
      while (n_beats < tgt && c < 50) begin
         @(posedge clk);
         c++;
      end
      chk("rst_mid_reach", int'(c < 50), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_s_tready", int'(s_tready), 0);
      chk("rst_mid_m_tvalid", int'(m_tvalid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_grant", int'(grant_id), 0);
      chk("rst_mid_trunc", int'(pkt_trunc), 0);
      rq0.delete(); rq1.delete();
      repeat (2) @(posedge clk); #2;
      send(0, 'h51, 2); send(1, 'h71, 1);
      expect_pkt(0, 'h51, 2, 2); expect_pkt(1, 'h71, 1, 1);
      @(negedge clk); rst_n = 1'b1;
      wait_done("post_rst_done", 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that shares the single 8-bit AXI-Stream path from the application/memory side toward the network TX FIFO among NUM_REQ requesters. Sits between the requesters inside the app/memory subsystem and the network TX FIFO interface. Once a requester is granted, the arbiter holds the grant for that requester until its packet ends (tlast), so frames are never interleaved. An optional length watchdog truncates runaway packets.

## Interface
Parameters:
- NUM_REQ, 2 — number of requesters, 2..8.
- DATA_WIDTH, 8 — tdata width, matches the network FIFO.
- MAX_PKT_LEN, 1518 — watchdog beat limit per packet. Only used with ARB_PKT_LEN_LIMIT_EN.

Ports:
- axis_aclk  in  1  — single clock for all ports.
- axis_aresetn  in  1  — asynchronous, active-low reset.
- s_axis_tdata  in  NUM_REQ*DATA_WIDTH  — requester data. Requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_REQ  — per-requester valid.
- s_axis_tlast  in  NUM_REQ  — per-requester end of packet.
- s_axis_tready  out  NUM_REQ  — per-requester ready.
- m_axis_tdata  out  DATA_WIDTH  — merged stream to the network TX FIFO.
- m_axis_tvalid  out  1  — merged valid.
- m_axis_tlast  out  1  — merged last.
- m_axis_tready  in  1  — ready from the TX FIFO.
- grant_id  out  clog2(NUM_REQ) (minimum 1)  — index of the current or most recent grant.
- busy  out  1  — high while in the XFER or DRAIN state.
- pkt_trunc  out  1  — sticky flag: a packet was truncated by the watchdog.

## Operation
The arbiter has three states:

- **IDLE**
  - All s_axis_tready = 0 and m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, select the first requester with tvalid high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Register the winner into grant_id and go to XFER on the next edge.
- **XFER** — combinational pass-through from the granted requester g:
  - m_axis_tdata = s_tdata[g]
  - m_axis_tvalid = s_tvalid[g]
  - m_axis_tlast = s_tlast[g]
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: set rr_ptr = (g+1) mod NUM_REQ and go to IDLE.
- **DRAIN** (only with the macro)
  - m_axis_tvalid = 0 and s_axis_tready[g] = 1.
  - Discard beats from g until a beat with s_tlast[g]=1 is accepted, then set rr_ptr = (g+1) mod NUM_REQ and go to IDLE.

Requester tvalid deasserting mid-packet is legal. The arbiter stays in XFER and the grant is held indefinitely.

Reset values:
- State = IDLE, rr_ptr = 0, grant_id = 0, busy = 0, pkt_trunc = 0, beat counter = 0.
- All s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
- m_axis_tdata is don't-care while m_axis_tvalid = 0.

## Timing
- Arbitration latency: a request seen in IDLE at edge N produces its first m_axis_tvalid in the cycle after edge N. There is one cycle of arbitration decision, with no registered data stage.
- There is one mandatory bubble cycle (IDLE) between consecutive packets, including back-to-back packets from the same requester.
- Handshake is standard AXI-S. A beat transfers only on tvalid & tready at a rising edge. The arbiter never drops a beat in XFER.
- Simultaneous requests are resolved by round-robin order only. The last-served requester gets lowest priority at the next arbitration.
- A single-beat packet (tlast on the first beat) takes XFER for exactly 1 cycle when m_axis_tready = 1.
- Asserting axis_aresetn low mid-packet forces IDLE immediately (asynchronous). The partial packet is not completed; downstream recovery is the FIFO's responsibility.

## Configuration
Macro: ARB_PKT_LEN_LIMIT_EN.

**Defined:**
- A beat counter of width clog2(MAX_PKT_LEN+1) counts accepted beats in XFER and clears on entry to XFER.
- When beat number MAX_PKT_LEN is accepted without s_tlast, the arbiter forces m_axis_tlast = 1 on that beat, sets pkt_trunc, and moves to DRAIN.
- pkt_trunc clears only on reset.

**Undefined:**
- No counter, no DRAIN state.
- Packets of any length pass unmodified.
- pkt_trunc is tied to 0.

## Test plan
- **Single requester:** req0 sends a 4-beat packet with m_axis_tready=1 → m_axis_tvalid is high for 4 consecutive cycles starting one cycle after req0 tvalid, tlast on beat 4, grant_id=0, busy=1 for those 4 cycles.
- **Contention:** req0 and req1 each continuously offer 3-beat packets → output order is req0, req1, req0, req1, with one idle cycle between packets and no interleaved beats.
- **Backpressure:** m_axis_tready toggles 1,0,1,0 during a 5-beat req1 packet → all 5 beats are delivered in order, s_axis_tready[1] mirrors m_axis_tready, and s_axis_tready[0] stays 0.
- **Truncation (macro defined, MAX_PKT_LEN=8):** req0 sends 12 beats → 8 beats are output with forced tlast on beat 8, beats 9–12 are accepted and discarded, pkt_trunc=1, and the next grant goes to req1 if it is requesting.
- **Reset mid-packet:** axis_aresetn is pulled low after beat 2 of 6 → in the same cycle all s_axis_tready=0, m_axis_tvalid=0, and busy=0. After release, rr_ptr=0 and the next arbitration grants req0 when both req0 and req1 request.
